x_input_streamer: RTL and testbench
===================================

// Module: x_input_streamer
// PURPOSE
//  Upstream feeder for the matrix core (top). Accepts X bytes from a host valid/ready port,
//  buffers up to BUF_MATS complete 32-byte matrices, and for each one issues a one-cycle
//  start_in, then streams the matrix on valid_input/X_load for MAT_LEN consecutive cycles.
//  Waits for the core's finish, idles GAP_CYC cycles, then launches the next buffered matrix.
// PARAMETERS
//  DATA_W      8    byte width of in_data / X_load
//  MAT_LEN     32   bytes per matrix (power of 2)
//  BUF_MATS    2    matrices of buffer storage (power of 2, >=2)
//  GAP_CYC     3    idle cycles between finish and next start_in (>=1)
//  TIMEOUT_CYC 4096 finish watchdog limit (used only with XSTREAM_TIMEOUT_EN)
// PORTS
//  clk          in   1       clock, all logic on posedge
//  rst          in   1       synchronous reset, active-high
//  in_valid     in   1       host byte valid
//  in_ready     out  1       buffer can accept a byte this cycle
//  in_data      in   DATA_W  host byte, row-major matrix order
//  start_in     out  1       one-cycle launch pulse to core
//  valid_input  out  1       X_load carries a valid byte
//  X_load       out  DATA_W  matrix byte to core; 0 when valid_input low
//  finish       in   1       core done with current matrix
//  busy         out  1       high in every state except IDLE
//  mats_done    out  16      matrices completed (finish seen), wraps at 2^16
//  timeout      out  1       sticky watchdog flag (tied 0 without XSTREAM_TIMEOUT_EN)
// BEHAVIOUR
//  - All outputs registered. Reset: in_ready=0 during rst, 1 first cycle after; start_in=0,
//    valid_input=0, X_load=0, busy=0, mats_done=0, timeout=0; buffer emptied, pointers=0.
//  - Buffer: circular, BUF_MATS*MAT_LEN bytes; byte occupancy counter occ.
//    in_ready = (occ < BUF_MATS*MAT_LEN). Write accepted when in_valid&in_ready.
//    Simultaneous write+read in one cycle: occ unchanged; legal even when full (ready from prior occ).
//    Pointers wrap modulo BUF_MATS*MAT_LEN; no data loss at wrap.
//  - full_mats = occ / MAT_LEN (complete matrices present, incl. the one streaming).
//  - FSM: IDLE -> START when full_mats>=1 (partial matrices never launch).
//    START (1 cyc): start_in=1. -> STREAM.
//    STREAM (MAT_LEN cyc): valid_input=1, X_load=byte k on cycle k, k=0..MAT_LEN-1,
//      no bubbles; byte freed from buffer as it is output. After byte MAT_LEN-1 -> WAIT_FIN.
//    WAIT_FIN: finish high one cycle -> GAP, mats_done+=1. finish in other states ignored.
//    GAP (GAP_CYC cyc) -> START if full_mats>=1 else IDLE.
//  - Latency: 32nd byte of a matrix accepted in cycle t with FSM in IDLE -> start_in in
//    t+2, first valid_input in t+3, last in t+3+MAT_LEN-1.
//  - Host writes continue during STREAM/WAIT_FIN/GAP; back-pressure only via in_ready.
//  - Reset mid-stream: aborts immediately, buffer contents discarded, outputs to reset values.
// CONFIGURATION
//  XSTREAM_TIMEOUT_EN defined: counter runs in WAIT_FIN; at TIMEOUT_CYC cycles without finish,
//   timeout<=1 (sticky until rst), FSM -> GAP, mats_done not incremented, next matrix proceeds.
//  Not defined: no counter, WAIT_FIN waits indefinitely, timeout constant 0.
// TESTING
//  1 Reset then write bytes 0..31 back-to-back -> start_in pulse 2 cyc after byte 31,
//    X_load=0..31 on 32 consecutive valid_input cycles, busy=1, X_load=0 after.
//  2 Write 31 bytes only -> no start_in for 100 cycles; 32nd byte -> launch as in 1.
//  3 Write 96 bytes continuously with finish held 0 -> in_ready drops once occ=64 (BUF_MATS=2),
//    rises as streaming frees bytes; all 96 bytes later delivered in order across 3 launches.
//  4 Two buffered matrices, finish pulsed 5 cyc after stream end -> start_in exactly GAP_CYC+1
//    cycles after finish; mats_done 0->1->2; finish pulsed in IDLE/STREAM has no effect.
//  5 Assert rst at byte 10 of STREAM -> next cycle valid_input=0, X_load=0, busy=0, occ=0;
//    fresh 32-byte write relaunches correctly.
//  6 With XSTREAM_TIMEOUT_EN, TIMEOUT_CYC=64, finish never driven -> timeout=1 after 64 cycles
//    in WAIT_FIN, mats_done stays 0, buffered 2nd matrix launches after GAP_CYC.

Source files
------------

// File: rtl/x_input_streamer.sv
// Buffers host X bytes into whole matrices and streams each one to the matrix core.
// Optional finish watchdog is compiled in with `define XSTREAM_TIMEOUT_EN.
module x_input_streamer #(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned MAT_LEN     = 32,
    parameter int unsigned BUF_MATS    = 2,
    parameter int unsigned GAP_CYC     = 3,
    parameter int unsigned TIMEOUT_CYC = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              start_in,
    output logic              valid_input,
    output logic [DATA_W-1:0] X_load,
    input  logic              finish,
    output logic              busy,
    output logic [15:0]       mats_done,
    output logic              timeout
);

    localparam int unsigned DEPTH = BUF_MATS * MAT_LEN;
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned OW    = $clog2(DEPTH + 1);
    localparam int unsigned CMAX0 = (MAT_LEN > GAP_CYC) ? MAT_LEN : GAP_CYC;
    localparam int unsigned CMAX  = (CMAX0 > TIMEOUT_CYC) ? CMAX0 : TIMEOUT_CYC;
    localparam int unsigned CW    = $clog2(CMAX + 1);

    typedef enum logic [2:0] {IDLE, START, STREAM, WAIT_FIN, GAP} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [OW-1:0]     occ_q, occ_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              in_ready_q, start_q, valid_q, busy_q;
    logic [DATA_W-1:0] xload_q;
    logic [15:0]       done_q, done_d;
    logic              wr_en, rd_en, have_mat;

    assign wr_en    = in_valid & in_ready_q;
    // A byte leaves the buffer on the edge that loads it into X_load.
    assign rd_en    = (state_d == STREAM);
    assign have_mat = (occ_q >= OW'(MAT_LEN));
    assign occ_d    = occ_q + OW'(wr_en) - OW'(rd_en);

`ifdef XSTREAM_TIMEOUT_EN
    logic timeout_q, timeout_d;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = done_q;
`ifdef XSTREAM_TIMEOUT_EN
        timeout_d = timeout_q;
`endif
        case (state_q)
            IDLE: begin
                if (have_mat) state_d = START;
            end
            START: begin
                state_d = STREAM;
                cnt_d   = '0;
            end
            STREAM: begin
                if (cnt_q == CW'(MAT_LEN - 1)) begin
                    state_d = WAIT_FIN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            WAIT_FIN: begin
                if (finish) begin
                    state_d = GAP;
                    cnt_d   = '0;
                    done_d  = done_q + 16'd1;
                end
`ifdef XSTREAM_TIMEOUT_EN
                else if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
                    state_d   = GAP;
                    cnt_d     = '0;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
`endif
            end
            GAP: begin
                if (cnt_q == CW'(GAP_CYC - 1)) begin
                    state_d = have_mat ? START : IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            occ_q      <= '0;
            in_ready_q <= 1'b0;
            start_q    <= 1'b0;
            valid_q    <= 1'b0;
            xload_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wr_ptr_q   <= wr_ptr_q + AW'(wr_en);
            rd_ptr_q   <= rd_ptr_q + AW'(rd_en);
            occ_q      <= occ_d;
            in_ready_q <= (occ_d < OW'(DEPTH));
            start_q    <= (state_d == START);
            valid_q    <= rd_en;
            xload_q    <= rd_en ? mem_q[rd_ptr_q] : '0;
            busy_q     <= (state_d != IDLE);
            done_q     <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= in_data;
    end

`ifdef XSTREAM_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) timeout_q <= 1'b0;
        else     timeout_q <= timeout_d;
    end
    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    assign in_ready    = in_ready_q;
    assign start_in    = start_q;
    assign valid_input = valid_q;
    assign X_load      = xload_q;
    assign busy        = busy_q;
    assign mats_done   = done_q;

endmodule

// File: tb/tb_x_input_streamer.sv
// Scoreboard bench for x_input_streamer: bytes written are queued, the monitor pops them
// as valid_input presents them; the main thread checks launch timing and counters.
module tb_x_input_streamer;

    localparam int MAT_LEN = 32;
    localparam int GAP_CYC = 3;
    localparam int TMO     = 64;

    logic        clk = 1'b0, rst = 1'b1, in_valid = 1'b0, finish = 1'b0;
    logic [7:0]  in_data = '0;
    logic        in_ready, start_in, valid_input, busy, timeout;
    logic [7:0]  X_load;
    logic [15:0] mats_done;

    int         tests = 0, fails = 0, cyc = 0, exp_done = 0, last_acc = 0;
    logic       mon_en = 1'b0;
    logic [7:0] exp_q[$];
    logic [7:0] mon_e;

    x_input_streamer #(
        .DATA_W(8), .MAT_LEN(MAT_LEN), .BUF_MATS(2), .GAP_CYC(GAP_CYC), .TIMEOUT_CYC(TMO)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .start_in(start_in), .valid_input(valid_input), .X_load(X_load), .finish(finish),
        .busy(busy), .mats_done(mats_done), .timeout(timeout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (valid_input) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_byte: got %0d, expected no byte", X_load);
                end else begin
                    tests--;
                    mon_e = exp_q.pop_front();
                    chk("X_load_data", X_load, mon_e);
                end
            end else begin
                chk("X_load_idle_zero", X_load, 0);
            end
        end
    end

    // Called at a negedge; returns at the negedge after the byte is accepted.
    task automatic put(input logic [7:0] b);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            tests++;
            fails++;
            $display("FAIL put_ready_timeout: in_ready got 0, expected 1");
        end else begin
            last_acc = cyc;
            exp_q.push_back(b);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_start(output int c);
        int n;
        n = 0;
        c = -1;
        while (!start_in && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (start_in) c = cyc;
        else begin
            tests++;
            fails++;
            $display("FAIL start_timeout: start_in got 0, expected 1");
        end
    endtask

    task automatic wait_stream(output int first, output int len);
        int n;
        n = 0;
        len = 0;
        while (!valid_input && n < 300) begin
            @(negedge clk);
            n++;
        end
        first = valid_input ? cyc : -1;
        while (valid_input && len < 300) begin
            len++;
            @(negedge clk);
        end
    endtask

    task automatic pulse_finish();
        finish = 1'b1;
        @(negedge clk);
        finish = 1'b0;
        exp_done++;
        chk("mats_done_after_finish", mats_done, exp_done & 16'hFFFF);
    endtask

    initial begin
        int t, c, f, first, len, e, tc, n;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_valid", valid_input, 0);
        chk("rst_start", start_in, 0);
        rst = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", in_ready, 1);
        chk("post_rst_mats_done", mats_done, 0);
        chk("post_rst_timeout", timeout, 0);

        // 1: one matrix, launch latency and contiguous stream
        for (int i = 0; i < 32; i++) put(8'(i));
        t = last_acc;
        wait_start(c);
        chk("t1_start_latency", c, t + 2);
        chk("t1_busy", busy, 1);
        wait_stream(first, len);
        chk("t1_first_valid", first, t + 3);
        chk("t1_stream_len", len, MAT_LEN);
        pulse_finish();

        // 2: partial matrix never launches
        for (int i = 0; i < 31; i++) put(8'(100 + i));
        n = 0;
        repeat (100) begin
            @(negedge clk);
            if (start_in) n++;
        end
        chk("t2_no_partial_launch", n, 0);
        put(8'(131));
        t = last_acc;
        wait_start(c);
        chk("t2_start_latency", c, t + 2);
        wait_stream(first, len);
        chk("t2_first_valid", first, t + 3);
        chk("t2_stream_len", len, MAT_LEN);
        pulse_finish();

        // 3: 96 bytes with finish held low fills the buffer
        for (int i = 0; i < 96; i++) put(8'(i * 3 + 7));
        chk("t3_full_not_ready", in_ready, 0);
        chk("t3_no_count_without_finish", mats_done, exp_done);
        pulse_finish();
        wait_start(c);
        wait_stream(first, len);
        chk("t3_stream2_len", len, MAT_LEN);
        chk("t3_ready_after_drain", in_ready, 1);
        pulse_finish();
        wait_start(c);
        wait_stream(first, len);
        chk("t3_stream3_len", len, MAT_LEN);
        pulse_finish();

        // 4: finish ignored outside WAIT_FIN; gap timing between matrices
        finish = 1'b1;
        @(negedge clk);
        finish = 1'b0;
        chk("t4_idle_finish_ignored", mats_done, exp_done);
        for (int i = 0; i < 64; i++) put(8'(200 + i));
        chk("t4_streaming", valid_input, 1);
        finish = 1'b1;
        @(negedge clk);
        finish = 1'b0;
        chk("t4_stream_finish_ignored", mats_done, exp_done);
        wait_stream(first, len);
        repeat (5) @(negedge clk);
        f = cyc;
        pulse_finish();
        wait_start(c);
        chk("t4_gap_to_start", c, f + GAP_CYC + 1);
        wait_stream(first, len);
        chk("t4_stream_len", len, MAT_LEN);
        pulse_finish();

        // 5: reset in the middle of a stream
        for (int i = 0; i < 32; i++) put(8'(50 + i));
        wait_start(c);
        @(negedge clk);
        chk("t5_streaming", valid_input, 1);
        repeat (10) @(negedge clk);
        #1;
        rst = 1'b1;
        exp_q.delete();
        exp_done = 0;
        @(negedge clk);
        chk("t5_rst_valid", valid_input, 0);
        chk("t5_rst_xload", X_load, 0);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_in_ready", in_ready, 0);
        chk("t5_rst_mats_done", mats_done, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("t5_post_rst_ready", in_ready, 1);
        for (int i = 0; i < 32; i++) put(8'(150 + i));
        t = last_acc;
        wait_start(c);
        chk("t5_relaunch_latency", c, t + 2);
        wait_stream(first, len);
        chk("t5_relaunch_first", first, t + 3);
        chk("t5_relaunch_len", len, MAT_LEN);
        pulse_finish();

        // 6: finish never arrives for the first of two buffered matrices
        for (int i = 0; i < 64; i++) put(8'(i ^ 8'h5A));
        wait_stream(first, len);
        e = cyc;
`ifdef XSTREAM_TIMEOUT_EN
        n = 0;
        while (!timeout && n < 300) begin
            @(negedge clk);
            n++;
        end
        tc = cyc;
        chk("t6_timeout_flag", timeout, 1);
        chk("t6_timeout_cycle", tc, e + TMO);
        chk("t6_no_count_on_timeout", mats_done, exp_done);
        wait_start(c);
        chk("t6_next_launch", c, tc + GAP_CYC);
        wait_stream(first, len);
        chk("t6_stream_len", len, MAT_LEN);
        pulse_finish();
        chk("t6_timeout_sticky", timeout, 1);
`else
        tc = e;
        n = 0;
        repeat (100) begin
            @(negedge clk);
            if (start_in || timeout) n++;
        end
        chk("t6_waits_for_finish", n, 0);
        chk("t6_waited_cycles", cyc - tc, 100);
        f = cyc;
        pulse_finish();
        wait_start(c);
        chk("t6_next_launch", c, f + GAP_CYC + 1);
        wait_stream(first, len);
        chk("t6_stream_len", len, MAT_LEN);
        pulse_finish();
`endif

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule
